mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Multi-cycle shift-and-add multiplier with a start/busy/done handshake, replacing the single-cycle combinational multiplier on the ALU MUL path.
- The CPU control unit raises START with the operands, holds the PC stall while BUSY is high, and writes RESULT back on DONE.
- RESULT is the low WIDTH bits of the product, matching the existing 8-bit MUL semantics. OVERFLOW reports any lost upper bits.

Parameters:
- WIDTH, 8, operand and result width in bits.
- EARLY_EXIT, 1, when 1 the operation terminates as soon as the remaining multiplier bits are all zero.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  request a new multiplication; sampled on the rising edge.
- DATA1  input  WIDTH  multiplicand; latched when START is accepted.
- DATA2  input  WIDTH  multiplier; latched when START is accepted.
- RESULT  output  WIDTH  low WIDTH bits of DATA1*DATA2 (unsigned).
- OVERFLOW  output  1  high when upper WIDTH bits of the full product are nonzero.
- BUSY  output  1  high while an operation is in progress (state RUN).
- DONE  output  1  one-cycle pulse; RESULT/OVERFLOW valid.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; RESULT=0, OVERFLOW=0, BUSY=0, DONE=0; internal accumulator, shifted multiplicand, multiplier and step counter all cleared. An in-flight operation is discarded; no DONE is produced for it.
- Internal registers:
  - acc: 2*WIDTH bits.
  - mcand: 2*WIDTH bits.
  - mplier: WIDTH bits.
  - cnt: clog2(WIDTH) bits.
- States: IDLE, RUN, FIN.
- IDLE: BUSY=0, DONE=0. If START=1 at an edge:
  - latch mcand={0,DATA1}, mplier=DATA2, acc=0, cnt=0;
  - go to RUN.
- RUN: BUSY=1. Each edge performs one step:
  - if mplier[0], acc=acc+mcand;
  - then mcand<<=1, mplier>>=1, cnt++.
  - Go to FIN at the edge where cnt==WIDTH-1 or (EARLY_EXIT=1 and the post-shift mplier==0).
  - At that same edge, RESULT=acc_next[WIDTH-1:0] and OVERFLOW=|acc_next[2*WIDTH-1:WIDTH], where acc_next includes the final step's add.
- FIN: DONE=1 and BUSY=0 for exactly one cycle, then IDLE.
  - START=1 at the FIN edge is accepted exactly as in IDLE: latch operands, go to RUN. This gives back-to-back operations with no idle bubble.
- Latency, measured from the edge accepting START:
  - EARLY_EXIT=0: DONE is high in the cycle after edge WIDTH (WIDTH RUN cycles).
  - EARLY_EXIT=1: RUN lasts max(1, index of DATA2's highest set bit + 1) cycles. DATA2=0 takes 1 RUN cycle.
- START while in RUN is ignored; no queuing. DATA1/DATA2 changes during RUN have no effect.
- RESULT and OVERFLOW hold their values from the last completed operation until the next completion or reset. They do not change when a new operation starts.
- Arithmetic is unsigned. The 2*WIDTH accumulator never wraps, since the product of two WIDTH-bit values fits in 2*WIDTH bits.

Test Plan:
- Reset then DATA1=3, DATA2=5, START 1 cycle, EARLY_EXIT=1 -> BUSY high 3 cycles, DONE pulse on 4th cycle, RESULT=15, OVERFLOW=0.
- EARLY_EXIT=0: DATA1=10, DATA2=5 -> BUSY exactly 8 cycles, then DONE, RESULT=50. Repeat with 8*5 -> RESULT=40.
- DATA1=255, DATA2=255 -> RESULT=0x01, OVERFLOW=1. Then 16*16 -> RESULT=0x00, OVERFLOW=1. Then 0*77 -> one RUN cycle, RESULT=0, OVERFLOW=0.
- Start 5*5, pulse START with 7*7 during RUN -> second request ignored, DONE once, RESULT=25. Then hold START high through the FIN cycle with 6*7 -> next op starts with no IDLE cycle, RESULT=42.
- Assert RESET asynchronously mid-way through 200*3 (between clock edges) -> BUSY, DONE, RESULT, OVERFLOW all 0 immediately. No DONE afterwards. A subsequent 2*9 returns 18.
- Hold DATA1/DATA2 changing every cycle during RUN of 12*11 -> RESULT=132, unaffected.

Source files
------------

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-and-add unsigned multiplier with a START/BUSY/DONE handshake.
// state | meaning:  IDLE | waiting for START;  RUN | one add/shift step per cycle;  FIN | DONE pulse, may accept START
module mul_sequencer #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             OVERFLOW,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 ovf_q, ovf_d;

  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     mplier_shift;
  logic                 last_step;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // The step result feeds both the datapath and the final RESULT capture.
  always_comb begin
    acc_step     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_shift = mplier_q >> 1;
    last_step    = (cnt_q == CW'(WIDTH - 1)) ||
                   ((EARLY_EXIT != 0) && (mplier_shift == '0));
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (START) begin
          mcand_d  = {{WIDTH{1'b0}}, DATA1};
          mplier_d = DATA2;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q + CW'(1);
        if (last_step) begin
          state_d  = S_FIN;
          result_d = acc_step[WIDTH-1:0];
          ovf_d    = |acc_step[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY     = (state_q == S_RUN);
    DONE     = (state_q == S_FIN);
    RESULT   = result_q;
    OVERFLOW = ovf_q;
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: instance 0 has EARLY_EXIT=0, instance 1 has EARLY_EXIT=1.
module tb_mul_sequencer;

  logic       CLK;
  logic       RESET;
  logic       start [2];
  logic [7:0] d1    [2];
  logic [7:0] d2    [2];
  logic [7:0] result[2];
  logic       ovf   [2];
  logic       busy  [2];
  logic       done  [2];

  int errors = 0;
  int checks = 0;

  mul_sequencer #(.WIDTH(8), .EARLY_EXIT(0)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .START(start[0]), .DATA1(d1[0]), .DATA2(d2[0]),
    .RESULT(result[0]), .OVERFLOW(ovf[0]), .BUSY(busy[0]), .DONE(done[0])
  );

  mul_sequencer #(.WIDTH(8), .EARLY_EXIT(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .START(start[1]), .DATA1(d1[1]), .DATA2(d2[1]),
    .RESULT(result[1]), .OVERFLOW(ovf[1]), .BUSY(busy[1]), .DONE(done[1])
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          u;
    int unsigned res;
    int unsigned ov;
    int          cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic product and highest-set-bit latency rule.
  function automatic int model_cycles(input int u, input logic [7:0] b);
    int h;
    if (u == 0) return 8;
    h = 0;
    for (int i = 0; i < 8; i++) if (b[i]) h = i + 1;
    return (h == 0) ? 1 : h;
  endfunction

  task automatic wait_done(input int u, output int nbusy, output bit ok);
    nbusy = 0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (done[u]) ok = 1'b1;
      else begin
        if (busy[u]) nbusy++;
        @(negedge CLK);
      end
    end
  endtask

  task automatic run_op(input int u, input logic [7:0] a, input logic [7:0] b,
                        input int unsigned exp_res, input int unsigned exp_ov,
                        input int exp_cyc, input string name);
    int n;
    bit ok;
    @(negedge CLK);
    start[u] = 1'b1; d1[u] = a; d2[u] = b;
    @(negedge CLK);
    start[u] = 1'b0; d1[u] = 8'($urandom); d2[u] = 8'($urandom);
    wait_done(u, n, ok);
    chk({name, " done_seen"}, 32'(ok), 32'd1);
    chk({name, " busy_cycles"}, n, exp_cyc);
    chk({name, " result"}, 32'(result[u]), exp_res);
    chk({name, " overflow"}, 32'(ovf[u]), exp_ov);
    @(negedge CLK);
    chk({name, " done_pulse_len"}, 32'(done[u]), 32'd0);
    chk({name, " busy_after"}, 32'(busy[u]), 32'd0);
  endtask

  initial begin
    int  n, ndone;
    bit  ok;
    logic [7:0] a, b;
    int unsigned p;
    int u;

    vecs[0] = '{a: 8'd3,   b: 8'd5,   u: 1, res: 15,  ov: 0, cyc: 3};
    vecs[1] = '{a: 8'd10,  b: 8'd5,   u: 0, res: 50,  ov: 0, cyc: 8};
    vecs[2] = '{a: 8'd8,   b: 8'd5,   u: 0, res: 40,  ov: 0, cyc: 8};
    vecs[3] = '{a: 8'd255, b: 8'd255, u: 1, res: 1,   ov: 1, cyc: 8};
    vecs[4] = '{a: 8'd16,  b: 8'd16,  u: 1, res: 0,   ov: 1, cyc: 5};
    vecs[5] = '{a: 8'd77,  b: 8'd0,   u: 1, res: 0,   ov: 0, cyc: 1};

    RESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; d1[i] = '0; d2[i] = '0;
    end
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset%0d busy", i), 32'(busy[i]), 0);
      chk($sformatf("reset%0d done", i), 32'(done[i]), 0);
      chk($sformatf("reset%0d result", i), 32'(result[i]), 0);
      chk($sformatf("reset%0d overflow", i), 32'(ovf[i]), 0);
    end
    RESET = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].u, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ov, vecs[i].cyc,
             $sformatf("vec%0d", i));

    // START during RUN ignored, then START held through FIN for back-to-back.
    @(negedge CLK);
    start[0] = 1'b1; d1[0] = 8'd5; d2[0] = 8'd5;
    @(negedge CLK);
    start[0] = 1'b0;
    @(negedge CLK);
    start[0] = 1'b1; d1[0] = 8'd7; d2[0] = 8'd7;
    @(negedge CLK);
    d1[0] = 8'd6; d2[0] = 8'd7;
    wait_done(0, n, ok);
    chk("ignore done_seen", 32'(ok), 1);
    chk("ignore busy_remaining", n, 6);
    chk("ignore result", 32'(result[0]), 25);
    @(negedge CLK);
    chk("b2b busy_no_bubble", 32'(busy[0]), 1);
    chk("b2b done_low", 32'(done[0]), 0);
    start[0] = 1'b0;
    wait_done(0, n, ok);
    chk("b2b done_seen", 32'(ok), 1);
    chk("b2b busy_cycles", n, 8);
    chk("b2b result", 32'(result[0]), 42);
    chk("b2b overflow", 32'(ovf[0]), 0);

    // Asynchronous reset between clock edges mid-operation.
    @(negedge CLK);
    start[0] = 1'b1; d1[0] = 8'd200; d2[0] = 8'd3;
    @(negedge CLK);
    start[0] = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("async busy", 32'(busy[0]), 0);
    chk("async done", 32'(done[0]), 0);
    chk("async result", 32'(result[0]), 0);
    chk("async overflow", 32'(ovf[0]), 0);
    @(negedge CLK);
    RESET = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (done[0]) ndone++;
    end
    chk("async no_done_after", ndone, 0);
    run_op(0, 8'd2, 8'd9, 18, 0, 8, "post_reset");

    // Operand inputs churn every cycle during RUN.
    @(negedge CLK);
    start[1] = 1'b1; d1[1] = 8'd12; d2[1] = 8'd11;
    @(negedge CLK);
    start[1] = 1'b0;
    n = 0; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (done[1]) ok = 1'b1;
      else begin
        if (busy[1]) n++;
        d1[1] = 8'($urandom); d2[1] = 8'($urandom);
        @(negedge CLK);
      end
    end
    chk("churn done_seen", 32'(ok), 1);
    chk("churn busy_cycles", n, 4);
    chk("churn result", 32'(result[1]), 132);
    chk("churn overflow", 32'(ovf[1]), 0);

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      u = i % 2;
      a = 8'($urandom_range(0, 255));
      b = (i % 3 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      p = 32'(a) * 32'(b);
      run_op(u, a, b, p & 32'hFF, ((p >> 8) != 0) ? 1 : 0, model_cycles(u, b),
             $sformatf("rand%0d_%0dx%0d", i, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
